rob_rename_buffer: RTL and testbench

- Per-ROB-entry result store with valid flags; sits beside the reorder buffer.
- The rename/dispatch stage looks up the ROB tags of two source operands (rob1, rob2) and gets each tag's value and whether that value exists yet.
- Entries are filled from the common data bus (CDB), cleared when a ROB entry is allocated, and cleared when the entry commits.

---
 rtl/rob_rename_buffer_pkg.sv | 19 +
 rtl/rob_rename_buffer_if.sv | 32 +++
 rtl/rob_rename_buffer.sv | 75 +++++++
 tb/tb_rob_rename_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rob_rename_buffer_pkg.sv
// Shared constants, tag type and read-port payload for the ROB rename buffer.
package rob_rename_buffer_pkg;

  localparam int unsigned WIDTH  = 31;
  localparam int unsigned ROB    = 2;
  localparam int unsigned DATA_W = WIDTH + 1;
  localparam int unsigned TAG_W  = ROB + 1;
  localparam int unsigned DEPTH  = 1 << TAG_W;

  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [DATA_W-1:0] rob_data_t;

  // One read port's answer: availability flag plus the value.
  typedef struct packed {
    logic      valid;
    rob_data_t value;
  } rob_rd_t;

endpackage

// File: rtl/rob_rename_buffer_if.sv
// CDB, allocation, commit and operand-lookup signals shared by the ROB and rename stage.
interface rob_rename_buffer_if;
  import rob_rename_buffer_pkg::*;

  logic      validBroadcast;
  rob_tag_t  robEntry;
  rob_data_t result;
  rob_tag_t  rob1;
  rob_tag_t  rob2;
  logic      robWrite;
  logic      freeze;
  rob_tag_t  robAllocation;
  logic      wcommit;
  rob_tag_t  ROBcommit;
  rob_data_t ROBValue1;
  rob_data_t ROBValue2;
  logic      valid1;
  logic      valid2;

  modport master (
    output validBroadcast, robEntry, result, rob1, rob2,
           robWrite, freeze, robAllocation, wcommit, ROBcommit,
    input  ROBValue1, ROBValue2, valid1, valid2
  );

  modport slave (
    input  validBroadcast, robEntry, result, rob1, rob2,
           robWrite, freeze, robAllocation, wcommit, ROBcommit,
    output ROBValue1, ROBValue2, valid1, valid2
  );

endinterface

// File: rtl/rob_rename_buffer.sv
// Per-ROB-entry result store with valid flags; two combinational lookup ports
// with CDB bypass so a result broadcast this cycle is visible immediately.
module rob_rename_buffer
  import rob_rename_buffer_pkg::*;
(
  input logic               clk,
  input logic               reset,
  rob_rename_buffer_if.slave bus
);

  rob_data_t              value_q [DEPTH];
  rob_data_t              value_d [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       valid_d;
  rob_rd_t                rd1;
  rob_rd_t                rd2;

  // Allocation clear beats CDB set, which beats commit clear, per entry.
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (bus.robWrite && !bus.freeze && bus.robAllocation == rob_tag_t'(e)) begin
        valid_d[e] = 1'b0;
      end else if (bus.validBroadcast && bus.robEntry == rob_tag_t'(e)) begin
        valid_d[e] = 1'b1;
        value_d[e] = bus.result;
      end else if (bus.wcommit && bus.ROBcommit == rob_tag_t'(e)) begin
        valid_d[e] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        value_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  function automatic rob_rd_t lookup(
    input rob_tag_t  tag,
    input logic      bcast,
    input rob_tag_t  bcast_tag,
    input rob_data_t bcast_data,
    input logic      stored_valid,
    input rob_data_t stored_value
  );
    rob_rd_t rd;
    if (bcast && bcast_tag == tag) begin
      rd.valid = 1'b1;
      rd.value = bcast_data;
    end else begin
      rd.valid = stored_valid;
      rd.value = stored_value;
    end
    return rd;
  endfunction

  assign rd1 = lookup(bus.rob1, bus.validBroadcast, bus.robEntry, bus.result,
                      valid_q[bus.rob1], value_q[bus.rob1]);
  assign rd2 = lookup(bus.rob2, bus.validBroadcast, bus.robEntry, bus.result,
                      valid_q[bus.rob2], value_q[bus.rob2]);

  assign bus.valid1    = rd1.valid;
  assign bus.ROBValue1 = rd1.value;
  assign bus.valid2    = rd2.valid;
  assign bus.ROBValue2 = rd2.value;

endmodule

// File: tb/tb_rob_rename_buffer.sv
// Scoreboard bench for rob_rename_buffer: directed scenarios then random traffic
// against an entry-array reference model.
module tb_rob_rename_buffer;
  import rob_rename_buffer_pkg::*;

  typedef struct {
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
  } exp_t;

  logic clk;
  logic reset;
  rob_rename_buffer_if bus();

  rob_rename_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          model_known = 1'b0;
  bit          m_valid [8];
  logic [31:0] m_value [8];

  // Reference answer for one lookup given the model and the current inputs.
  function automatic void ref_read(input logic [2:0] tag, input bit bc, input logic [2:0] ent,
                                   input logic [31:0] res, output logic v, output logic [31:0] d);
    if (bc && ent == tag) begin
      v = 1'b1;
      d = res;
    end else begin
      v = m_valid[tag];
      d = m_value[tag];
    end
  endfunction

  // One clock of stimulus: drive, record expectation, advance the model, wait for the edge.
  task automatic step(input bit rst, input bit bc, input logic [2:0] ent, input logic [31:0] res,
                      input logic [2:0] r1, input logic [2:0] r2,
                      input bit wr, input bit fz, input logic [2:0] al,
                      input bit wc, input logic [2:0] ct);
    exp_t e;
    reset              = rst;
    bus.validBroadcast = bc;
    bus.robEntry       = ent;
    bus.result         = res;
    bus.rob1           = r1;
    bus.rob2           = r2;
    bus.robWrite       = wr;
    bus.freeze         = fz;
    bus.robAllocation  = al;
    bus.wcommit        = wc;
    bus.ROBcommit      = ct;
    if (model_known) begin
      ref_read(r1, bc, ent, res, e.v1, e.d1);
      ref_read(r2, bc, ent, res, e.v2, e.d2);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        m_valid[i] = 1'b0;
        m_value[i] = 32'h0;
      end else if (wr && !fz && al == 3'(i)) begin
        m_valid[i] = 1'b0;
      end else if (bc && ent == 3'(i)) begin
        m_valid[i] = 1'b1;
        m_value[i] = res;
      end else if (wc && ct == 3'(i)) begin
        m_valid[i] = 1'b0;
      end
    end
    if (rst) model_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2);
    step(1'b0, 1'b0, 3'd0, 32'h0, r1, r2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  // Monitor: the read ports answer every cycle, so compare mid-cycle whenever an expectation waits.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.valid1 !== e.v1 || bus.ROBValue1 !== e.d1) begin
        errors++;
        $display("FAIL port1 t=%0t rob1=%0d got v=%0b d=%h expected v=%0b d=%h",
                 $time, bus.rob1, bus.valid1, bus.ROBValue1, e.v1, e.d1);
      end
      checks++;
      if (bus.valid2 !== e.v2 || bus.ROBValue2 !== e.d2) begin
        errors++;
        $display("FAIL port2 t=%0t rob2=%0d got v=%0b d=%h expected v=%0b d=%h",
                 $time, bus.rob2, bus.valid2, bus.ROBValue2, e.v2, e.d2);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.validBroadcast = 1'b0;
    bus.robEntry = '0;
    bus.result = '0;
    bus.rob1 = '0;
    bus.rob2 = '0;
    bus.robWrite = 1'b0;
    bus.freeze = 1'b0;
    bus.robAllocation = '0;
    bus.wcommit = 1'b0;
    bus.ROBcommit = '0;
    @(posedge clk);
    #1;

    // Reset, then every entry reads back empty.
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

    // CDB write with same-cycle bypass, then stored read.
    step(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    idle(3'd3, 3'd3);

    // Allocation clears the entry; frozen allocation does not.
    step(1'b0, 1'b0, 3'd0, 32'h0, 3'd3, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0, 3'd0);
    idle(3'd3, 3'd3);
    step(1'b0, 1'b1, 3'd3, 32'h55, 3'd3, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
    idle(3'd3, 3'd3);

    // Commit vs CDB on the same entry, then on different entries.
    step(1'b0, 1'b1, 3'd5, 32'd7, 3'd5, 3'd6, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5);
    idle(3'd5, 3'd5);
    step(1'b0, 1'b1, 3'd6, 32'd7, 3'd5, 3'd6, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5);
    idle(3'd5, 3'd6);

    // Allocation beats CDB on the same entry, but the bypass still shows the result.
    step(1'b0, 1'b1, 3'd2, 32'd9, 3'd2, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0, 3'd0);
    idle(3'd2, 3'd2);

    // Wrap-around allocation 6,7,0,1 with results 100..103, then a reset mid-stream.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 3'd0, 32'h0, 3'(6 + k), 3'd4, 1'b1, 1'b0, 3'(6 + k), 1'b0, 3'd0);
      step(1'b0, 1'b1, 3'(6 + k), 32'(100 + k), 3'(6 + k), 3'(5 + k), 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    end
    for (int k = 0; k < 4; k++) idle(3'(6 + k), 3'(7 + k));
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) idle(3'(6 + k), 3'(6 + k));

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 3'($urandom), $urandom,
           3'($urandom), 3'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           3'($urandom), $urandom_range(0, 2) == 0, 3'($urandom));
    end

    // Drain: every expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
